onewire_master: RTL



---
 rtl/onewire_pkg.sv | 61 ++++++
 rtl/onewire_tick_gen.sv | 39 +++
 rtl/onewire_master.sv | 135 +++++++++++++
 3 files changed

// File: rtl/onewire_pkg.sv
// +----------------------------------------------------------------------------+
// | onewire_pkg : command encodings, FSM states and slot timing for the 1-Wire  |
// | master.                                                                    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

package onewire_pkg;

    localparam logic [1:0] TYP_RST    = 2'b00;
    localparam logic [1:0] TYP_BIT    = 2'b01;
    localparam logic [1:0] TYP_IDLE   = 2'b10;
    localparam logic [1:0] TYP_IDLE_R = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_REL  = 2'd2,
        ST_REC  = 2'd3
    } state_t;

    localparam int TW = 10;

    // Slot timing in ticks: low duration / sample point / slot end
    localparam logic [TW-1:0] RST_LOW = 10'd480;
    localparam logic [TW-1:0] RST_SMP = 10'd550;
    localparam logic [TW-1:0] RST_END = 10'd960;
    localparam logic [TW-1:0] B0_LOW  = 10'd60;
    localparam logic [TW-1:0] B0_SMP  = 10'd15;
    localparam logic [TW-1:0] B0_END  = 10'd70;
    localparam logic [TW-1:0] B1_LOW  = 10'd6;
    localparam logic [TW-1:0] B1_SMP  = 10'd15;
    localparam logic [TW-1:0] B1_END  = 10'd70;
    localparam logic [TW-1:0] IDL_LOW = 10'd0;
    localparam logic [TW-1:0] IDL_SMP = 10'd0;
    localparam logic [TW-1:0] IDL_END = 10'd70;

    typedef struct packed {
        logic [TW-1:0] low;
        logic [TW-1:0] smp;
        logic [TW-1:0] fin;
        logic          has_smp;
        logic          inv;      // presence is reported as an inverted bus level
    } slot_t;

    function automatic slot_t slot_of(input logic [1:0] typ, input logic dat);
        slot_t s;
        case (typ)
            TYP_RST: s = '{low: RST_LOW, smp: RST_SMP, fin: RST_END, has_smp: 1'b1, inv: 1'b1};
            TYP_BIT: begin
                if (dat) s = '{low: B1_LOW, smp: B1_SMP, fin: B1_END, has_smp: 1'b1, inv: 1'b0};
                else     s = '{low: B0_LOW, smp: B0_SMP, fin: B0_END, has_smp: 1'b1, inv: 1'b0};
            end
            default: s = '{low: IDL_LOW, smp: IDL_SMP, fin: IDL_END, has_smp: 1'b0, inv: 1'b0};
        endcase
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/onewire_tick_gen.sv
// +----------------------------------------------------------------------------+
// | onewire_tick_gen : clock divider producing the slot tick strobe.           |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module onewire_tick_gen #(
    parameter int CDR_N = 10,
    parameter int CDR_O = 1,
    parameter int CDW   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic ovd,
    input  logic en,
    output logic tick
);

    logic [CDW-1:0] r_div;
    logic [CDW-1:0] r_per;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
            r_per <= CDW'(CDR_N);
        end else if (load) begin
            r_div <= '0;
            r_per <= ovd ? CDW'(CDR_O) : CDW'(CDR_N);
        end else if (en) begin
            r_div <= tick ? '0 : r_div + 1'b1;
        end
    end

    assign tick = en && (r_div == r_per - 1'b1);

endmodule

`default_nettype wire

// File: rtl/onewire_master.sv
// +----------------------------------------------------------------------------+
// | onewire_master : 1-Wire bus master, one timeslot per accepted command.     |
// | Option macro   : ONEWIRE_MASTER_STRONG_PULLUP_EN (cmd_pwr / owr_e)         |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
`default_nettype none

module onewire_master
    import onewire_pkg::*;
#(
    parameter int CDR_N = 10,
    parameter int CDR_O = 1,
    parameter int CDW   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_typ,
    input  logic       cmd_dat,
    input  logic       cmd_ovd,
    output logic       rsp_valid,
    output logic       rsp_dat,
    output logic       owr_p,
    input  logic       owr_i
`ifdef ONEWIRE_MASTER_STRONG_PULLUP_EN
   ,input  logic       cmd_pwr,
    output logic       owr_e
`endif
);

    state_t        r_state;
    slot_t         r_slot;
    slot_t         w_slot;
    logic [1:0]    r_sync;
    logic [TW-1:0] r_tcnt;
    logic [TW-1:0] w_tnext;
    logic          r_smp_bit;
    logic          w_tick;
    logic          w_accept;
`ifdef ONEWIRE_MASTER_STRONG_PULLUP_EN
    logic          r_pwr;
`endif

    assign w_accept = cmd_valid && cmd_ready;
    assign w_slot   = slot_of(cmd_typ, cmd_dat);
    assign w_tnext  = r_tcnt + 1'b1;

    onewire_tick_gen #(
        .CDR_N (CDR_N),
        .CDR_O (CDR_O),
        .CDW   (CDW)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .load  (w_accept),
        .ovd   (cmd_ovd),
        .en    (r_state != ST_IDLE),
        .tick  (w_tick)
    );

    // Idle bus level is high, so the synchronizer starts there
    always_ff @(posedge clk) begin
        if (rst) r_sync <= 2'b11;
        else     r_sync <= {r_sync[0], owr_i};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_slot    <= '0;
            r_tcnt    <= '0;
            r_smp_bit <= 1'b0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_dat   <= 1'b0;
            owr_p     <= 1'b0;
`ifdef ONEWIRE_MASTER_STRONG_PULLUP_EN
            r_pwr     <= 1'b0;
            owr_e     <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            if (w_tick && r_tcnt != r_slot.fin)
                r_tcnt <= w_tnext;
            // Sampling is independent of state: a bit-0 slot samples while still driving low
            if (w_tick && r_slot.has_smp && w_tnext == r_slot.smp)
                r_smp_bit <= r_slot.inv ? ~r_sync[1] : r_sync[1];
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_slot    <= w_slot;
                        r_tcnt    <= '0;
                        cmd_ready <= 1'b0;
`ifdef ONEWIRE_MASTER_STRONG_PULLUP_EN
                        r_pwr     <= cmd_pwr;
                        owr_e     <= 1'b0;
`endif
                        if (w_slot.low == '0) begin
                            r_state <= ST_REL;
                        end else begin
                            r_state <= ST_LOW;
                            owr_p   <= 1'b1;
                        end
                    end
                end
                ST_LOW: begin
                    if (w_tick && w_tnext == r_slot.low) begin
                        owr_p   <= 1'b0;
                        r_state <= (r_slot.smp <= r_slot.low) ? ST_REC : ST_REL;
                    end
                end
                ST_REL: begin
                    if (!r_slot.has_smp || (w_tick && w_tnext == r_slot.smp))
                        r_state <= ST_REC;
                end
                ST_REC: begin
                    if (w_tick && w_tnext == r_slot.fin) begin
                        r_state   <= ST_IDLE;
                        cmd_ready <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_dat   <= r_slot.has_smp ? r_smp_bit : 1'b0;
`ifdef ONEWIRE_MASTER_STRONG_PULLUP_EN
                        owr_e     <= r_pwr;
`endif
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
